// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC time-stamp engine: derived widths, record layout, encoder mode.
// No logic, no latency.
// Encoder mode follows TDC_BUBBLE_FIX_EN (popcount when defined, leading-ones otherwise).
package tdc_pkg;

    typedef enum logic {
        ENC_LEADING_ONES = 1'b0,
        ENC_POPCOUNT     = 1'b1
    } enc_mode_e;

`ifdef TDC_BUBBLE_FIX_EN
    localparam enc_mode_e ENC_MODE = ENC_POPCOUNT;
`else
    localparam enc_mode_e ENC_MODE = ENC_LEADING_ONES;
`endif

    // Channel tag width; a single channel still carries a 1-bit tag.
    function automatic int ch_w_f(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Fine value ranges over 0..TAPS inclusive.
    function automatic int fine_w_f(input int taps);
        return $clog2(taps + 1);
    endfunction

    // Record layout {channel, coarse, fine}, fine in the LSBs.
    localparam int FINE_LSB = 0;

    function automatic int coarse_lsb_f(input int fine_w);
        return fine_w;
    endfunction

    function automatic int ch_lsb_f(input int fine_w, input int coarse_w);
        return fine_w + coarse_w;
    endfunction

endpackage

// File: rtl/tdc_therm_enc.sv
// Thermometer-to-binary fine encoder for one delay-line channel.
// Combinational, zero latency; no flow control.
// TDC_BUBBLE_FIX_EN selects popcount (bubble tolerant) instead of leading-ones count.
module tdc_therm_enc
    import tdc_pkg::*;
#(
    parameter  int TAPS   = 128,
    localparam int FINE_W = fine_w_f(TAPS)
) (
    input  logic [TAPS-1:0]   therm_i,
    output logic [FINE_W-1:0] fine_o
);

`ifdef TDC_BUBBLE_FIX_EN
    // Count every set tap so isolated bubbles near the edge still land on the right bin.
    always_comb begin
        fine_o = '0;
        for (int i = 0; i < TAPS; i++) begin
            fine_o = fine_o + FINE_W'(therm_i[i]);
        end
    end
`else
    // Length of the unbroken run of ones starting at tap 0.
    always_comb begin
        logic run;
        run    = 1'b1;
        fine_o = '0;
        for (int i = 0; i < TAPS; i++) begin
            run    = run & therm_i[i];
            fine_o = fine_o + FINE_W'(run);
        end
    end
`endif

endmodule

// File: rtl/tdc_stamp_engine.sv
// Multi-channel TDC time stamper: per-hit {channel, coarse, fine} records queued in a show-ahead FIFO.
// Hit at edge k -> rec_valid after edge k+1 (k+2 with TDC_BUBBLE_FIX_EN, which adds an encoder register).
// rec_ready low holds rec_data; a full FIFO stalls the slots, and a hit on an occupied slot is dropped and counted.
module tdc_stamp_engine
    import tdc_pkg::*;
#(
    parameter  int NCH        = 2,
    parameter  int TAPS       = 128,
    parameter  int COARSE_W   = 16,
    parameter  int FIFO_DEPTH = 16,
    parameter  int DROP_W     = 8,
    localparam int CH_W       = ch_w_f(NCH),
    localparam int FINE_W     = fine_w_f(TAPS),
    localparam int REC_W      = CH_W + COARSE_W + FINE_W,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NCH-1:0]      hit_i,
    input  logic [NCH*TAPS-1:0] therm_i,
    output logic [REC_W-1:0]    rec_data,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [DROP_W-1:0]   drop_cnt,
    output logic [LVL_W-1:0]    fifo_level
);

    localparam int AW         = LVL_W - 1;
    localparam int DSUM_W     = DROP_W + 4;
    localparam int COARSE_LSB = coarse_lsb_f(FINE_W);
    localparam int CH_LSB     = ch_lsb_f(FINE_W, COARSE_W);

    logic [COARSE_W-1:0] coarse_q;
    logic [NCH-1:0]      hit_q;
    logic [NCH-1:0]      rise;
    logic [FINE_W-1:0]   fine [NCH];

    logic [NCH-1:0]      cap_vld;
    logic [COARSE_W-1:0] cap_coarse;
    logic [FINE_W-1:0]   cap_fine [NCH];

    logic [NCH-1:0]      slot_vld_q;
    logic [COARSE_W-1:0] slot_coarse_q [NCH];
    logic [FINE_W-1:0]   slot_fine_q [NCH];

    logic [NCH-1:0]      hi_req;
    logic [NCH-1:0]      drain;
    logic                hi_found, lo_found, gnt_vld;
    logic [CH_W-1:0]     hi_idx, lo_idx, gnt_idx;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [DSUM_W-1:0]   drop_sum;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic [REC_W-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]         wr_q, rd_q;
    logic                full, empty, push, pop;
    logic [REC_W-1:0]    push_dat;

    for (genvar c = 0; c < NCH; c++) begin : g_enc
        tdc_therm_enc #(.TAPS(TAPS)) u_enc (
            .therm_i (therm_i[c*TAPS +: TAPS]),
            .fine_o  (fine[c])
        );
    end

    // Free-running coarse time base (parked at 0 while disabled) and hit edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coarse_q <= '0;
            hit_q    <= '0;
        end else begin
            coarse_q <= enable ? coarse_q + COARSE_W'(1) : '0;
            hit_q    <= hit_i;
        end
    end

    assign rise = hit_i & ~hit_q & {NCH{enable}};

`ifdef TDC_BUBBLE_FIX_EN
    logic [NCH-1:0]      pipe_vld_q;
    logic [COARSE_W-1:0] pipe_coarse_q;
    logic [FINE_W-1:0]   pipe_fine_q [NCH];

    // Register the popcount result; the coarse stamp travels with it so it still reflects the hit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q    <= '0;
            pipe_coarse_q <= '0;
            for (int c = 0; c < NCH; c++) pipe_fine_q[c] <= '0;
        end else begin
            pipe_vld_q    <= rise;
            pipe_coarse_q <= coarse_q;
            pipe_fine_q   <= fine;
        end
    end

    assign cap_vld    = pipe_vld_q;
    assign cap_coarse = pipe_coarse_q;
    assign cap_fine   = pipe_fine_q;
`else
    assign cap_vld    = rise;
    assign cap_coarse = coarse_q;
    assign cap_fine   = fine;
`endif

    assign pop  = rec_valid & rec_ready;
    assign push = gnt_vld;

    // Round-robin pick: lowest valid slot at or above rr_q, else lowest valid slot overall.
    assign hi_req = slot_vld_q & ({NCH{1'b1}} << rr_q);

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (hi_req[c]) begin
                hi_found = 1'b1;
                hi_idx   = CH_W'(c);
            end
            if (slot_vld_q[c]) begin
                lo_found = 1'b1;
                lo_idx   = CH_W'(c);
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
        gnt_vld = lo_found && (!full || pop);
        rr_d    = rr_q;
        if (gnt_vld) rr_d = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

    // Per-slot drain flags and the saturating drop count for hits landing on a busy slot.
    always_comb begin
        drain    = '0;
        drop_sum = {4'b0, drop_q};
        for (int c = 0; c < NCH; c++) begin
            drain[c] = gnt_vld && (gnt_idx == CH_W'(c));
            if (cap_vld[c] && slot_vld_q[c] && !drain[c]) drop_sum = drop_sum + DSUM_W'(1);
        end
        drop_d = (drop_sum > {4'b0, {DROP_W{1'b1}}}) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end

    // Slot load on capture (a slot draining this cycle may be refilled), clear on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                slot_coarse_q[c] <= '0;
                slot_fine_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cap_vld[c] && (!slot_vld_q[c] || drain[c])) begin
                    slot_vld_q[c]    <= 1'b1;
                    slot_coarse_q[c] <= cap_coarse;
                    slot_fine_q[c]   <= cap_fine[c];
                end else if (drain[c]) begin
                    slot_vld_q[c] <= 1'b0;
                end
            end
        end
    end

    // Assemble the granted slot into a record.
    always_comb begin
        push_dat                            = '0;
        push_dat[CH_LSB +: CH_W]            = gnt_idx;
        push_dat[COARSE_LSB +: COARSE_W]    = slot_coarse_q[gnt_idx];
        push_dat[FINE_LSB +: FINE_W]        = slot_fine_q[gnt_idx];
    end

    // Record storage; at full with a pop, the write lands in the entry being vacated.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q[AW-1:0]] <= push_dat;
    end

    // FIFO pointers, arbitration pointer and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            rr_q   <= '0;
            drop_q <= '0;
        end else begin
            wr_q   <= wr_q + LVL_W'(push);
            rd_q   <= rd_q + LVL_W'(pop);
            rr_q   <= rr_d;
            drop_q <= drop_d;
        end
    end

    assign fifo_level = wr_q - rd_q;
    assign empty      = (wr_q == rd_q);
    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign rec_valid  = ~empty;
    assign rec_data   = rec_valid ? mem[rd_q[AW-1:0]] : '0;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_tdc_stamp_engine.sv
// Directed bench for tdc_stamp_engine at NCH=2, TAPS=128, COARSE_W=16, FIFO_DEPTH=16, DROP_W=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Latency and bubble expectations follow TDC_BUBBLE_FIX_EN.
module tb_tdc_stamp_engine;

    localparam int TAPS = 128;
`ifdef TDC_BUBBLE_FIX_EN
    localparam int         PIPE        = 1;
    localparam logic [7:0] BUBBLE_FINE = 8'd5;
`else
    localparam int         PIPE        = 0;
    localparam logic [7:0] BUBBLE_FINE = 8'd3;
`endif

    logic         clk, rst, enable, rec_ready, rec_valid;
    logic [1:0]   hit_i;
    logic [255:0] therm_i;
    logic [24:0]  rec_data;
    logic [7:0]   drop_cnt;
    logic [4:0]   fifo_level;

    logic [15:0]  mc;
    logic [15:0]  hc;
    logic [15:0]  c_arr [16];
    logic [TAPS-1:0] bub;
    int checks = 0;
    int errors = 0;

    tdc_stamp_engine #(
        .NCH(2), .TAPS(TAPS), .COARSE_W(16), .FIFO_DEPTH(16), .DROP_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .hit_i      (hit_i),
        .therm_i    (therm_i),
        .rec_data   (rec_data),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; mc mirrors the coarse counter's current value.
    task automatic tick();
        @(posedge clk);
        if (rst)         mc = 16'h0000;
        else if (enable) mc = mc + 16'h0001;
        else             mc = 16'h0000;
        #1;
    endtask

    function automatic logic [TAPS-1:0] lead(input int n);
        logic [TAPS-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [24:0] rec(input logic ch, input logic [15:0] c, input logic [7:0] f);
        return {ch, c, f};
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        hit_i     = 2'b00;
        rec_ready = 1'b1;
        therm_i   = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One isolated hit with an empty FIFO and rec_ready high: exact latency, data, one-cycle valid.
    task automatic hit_one(input int ch, input logic [TAPS-1:0] th, input logic [15:0] ec,
                           input logic [7:0] ef, input string tag);
        logic [24:0] e;
        e = rec(ch[0], ec, ef);
        therm_i[ch*TAPS +: TAPS] = th;
        hit_i[ch] = 1'b1;
        tick();
        hit_i[ch] = 1'b0;
        repeat (PIPE) tick();
        check({tag, "_early"}, 64'(rec_valid), 64'(0));
        tick();
        check({tag, "_valid"}, 64'(rec_valid), 64'(1));
        check({tag, "_data"}, 64'(rec_data), 64'(e));
        tick();
        check({tag, "_gone"}, 64'(rec_valid), 64'(0));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; hit_i = 2'b00; rec_ready = 1'b1; therm_i = '0; mc = '0;
        #3;
        check("rst_valid", 64'(rec_valid), 64'(0));
        check("rst_data",  64'(rec_data),  64'(0));
        check("rst_drop",  64'(drop_cnt),  64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));

        // Single hit at coarse 0x0100, 37 leading ones.
        do_reset();
        enable = 1'b1;
        repeat (256) tick();
        hit_one(0, lead(37), 16'h0100, 8'd37, "single");
        check("single_drop", 64'(drop_cnt), 64'(0));

        // Simultaneous hits: ch0 then ch1, and the pointer returns to 0.
        do_reset();
        enable = 1'b1;
        therm_i[0 +: TAPS]    = lead(10);
        therm_i[TAPS +: TAPS] = lead(20);
        for (int r = 0; r < 2; r++) begin
            hc = mc;
            hit_i = 2'b11;
            tick();
            hit_i = 2'b00;
            repeat (PIPE) tick();
            check("sim_early", 64'(rec_valid), 64'(0));
            tick();
            check("sim_first", 64'(rec_data), 64'(rec(1'b0, hc, 8'd10)));
            tick();
            check("sim_second", 64'(rec_data), 64'(rec(1'b1, hc, 8'd20)));
            tick();
            check("sim_empty", 64'(rec_valid), 64'(0));
        end

        // Encoder boundaries.
        bub = '0;
        bub[7:0] = 8'b0011_0111;
        hit_one(0, lead(128), mc, 8'd128, "all_ones");
        hit_one(1, '0, mc, 8'd0, "all_zeros");
        hit_one(0, bub, mc, BUBBLE_FINE, "bubble");

        // Coarse wrap 0xFFFF -> 0x0000 across two consecutive hit edges.
        do_reset();
        enable = 1'b1;
        repeat (65535) tick();
        therm_i[0 +: TAPS]    = lead(11);
        therm_i[TAPS +: TAPS] = lead(22);
        hit_i = 2'b01;
        tick();
        hit_i = 2'b11;
        tick();
        hit_i = 2'b00;
        repeat (PIPE) tick();
        check("wrap_ffff", 64'(rec_data), 64'(rec(1'b0, 16'hFFFF, 8'd11)));
        tick();
        check("wrap_0000", 64'(rec_data), 64'(rec(1'b1, 16'h0000, 8'd22)));
        tick();
        check("wrap_empty", 64'(rec_valid), 64'(0));

        // Disabled: no capture; re-enabled coarse restarts at 0.
        enable = 1'b0;
        tick();
        hit_i[0] = 1'b1;
        repeat (3) tick();
        check("dis_level", 64'(fifo_level), 64'(0));
        check("dis_valid", 64'(rec_valid), 64'(0));
        hit_i[0] = 1'b0;
        tick();
        enable = 1'b1;
        hit_one(0, lead(9), 16'h0000, 8'd9, "reenable");

        // Backpressure: 16 hits fill the FIFO.
        do_reset();
        enable = 1'b1;
        rec_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            therm_i[0 +: TAPS] = lead(i + 1);
            c_arr[i] = mc;
            hit_i[0] = 1'b1;
            tick();
            hit_i[0] = 1'b0;
            repeat (3) tick();
            check("fill_level", 64'(fifo_level), 64'(i + 1));
        end
        check("full_head", 64'(rec_data), 64'(rec(1'b0, c_arr[0], 8'd1)));
        therm_i[TAPS +: TAPS] = lead(50);
        hit_i[1] = 1'b1;
        tick();
        hit_i[1] = 1'b0;
        repeat (3) tick();
        check("blocked_level", 64'(fifo_level), 64'(16));
        check("blocked_head", 64'(rec_data), 64'(rec(1'b0, c_arr[0], 8'd1)));
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        check("pushpop_level", 64'(fifo_level), 64'(16));
        check("pushpop_head", 64'(rec_data), 64'(rec(1'b0, c_arr[1], 8'd2)));

        // Drops: FIFO full, ch0 slot occupied.
        hit_i[0] = 1'b1; tick(); hit_i[0] = 1'b0; tick();
        hit_i[0] = 1'b1; tick(); hit_i[0] = 1'b0; tick();
        tick();
        check("drop_one", 64'(drop_cnt), 64'(1));
        repeat (253) begin
            hit_i[0] = 1'b1; tick(); hit_i[0] = 1'b0; tick();
        end
        tick();
        check("drop_254", 64'(drop_cnt), 64'(254));
        hit_i[0] = 1'b1; tick(); hit_i[0] = 1'b0; tick();
        tick();
        check("drop_255", 64'(drop_cnt), 64'(255));
        repeat (46) begin
            hit_i[0] = 1'b1; tick(); hit_i[0] = 1'b0; tick();
        end
        tick();
        check("drop_sat", 64'(drop_cnt), 64'(255));

        // Drain everything, then hold five records and reset asynchronously.
        rec_ready = 1'b1;
        repeat (20) tick();
        check("drain_level", 64'(fifo_level), 64'(0));
        check("drain_drop", 64'(drop_cnt), 64'(255));
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hit_i[0] = 1'b1; tick(); hit_i[0] = 1'b0;
            repeat (3) tick();
        end
        check("five_level", 64'(fifo_level), 64'(5));
        rst = 1'b1;
        #2;
        check("arst_level", 64'(fifo_level), 64'(0));
        check("arst_valid", 64'(rec_valid), 64'(0));
        check("arst_drop", 64'(drop_cnt), 64'(0));
        check("arst_data", 64'(rec_data), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        rec_ready = 1'b1;
        hit_one(0, lead(7), 16'h0000, 8'd7, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_stamp_engine.md
Name: tdc_stamp_engine

Overview:
- Multi-channel time-stamping back end for the delay-line TDC platform.
- Each channel supplies a sampled delay-line thermometer code and a hit strobe.
- Per hit, the block encodes the fine position, combines it with a free-running coarse counter, and queues a tagged record in a FIFO.
- The FIFO drains over a valid/ready stream to the UART framer. Generalises the single-channel, fixed-length capture path to NCH channels, parametrised tap count and buffering.

Parameters:
- NCH, 2: number of TDC channels (1..8).
- TAPS, 128: delay-line taps per channel.
- COARSE_W, 16: coarse counter width.
- FIFO_DEPTH, 16: record FIFO depth; must be a power of two.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  sampling clock, same clock as the delay-line sampling registers.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  capture enable.
- hit_i  in  NCH  per-channel hit level, already synchronous to clk.
- therm_i  in  NCH*TAPS  sampled thermometer codes; channel c occupies bits [c*TAPS +: TAPS].
- rec_data  out  CH_W+COARSE_W+FINE_W  record {channel, coarse, fine}, channel in the MSBs.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- drop_cnt  out  DROP_W  hits lost, saturating.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.

Derived widths: CH_W = max(1, clog2(NCH)); FINE_W = clog2(TAPS+1).

Behaviour:
- Reset values: all outputs 0; the coarse counter, edge-detect registers, slots, FIFO pointers and round-robin pointer are all 0.
- Coarse counter:
  - Increments every cycle while enable=1 and wraps modulo 2^COARSE_W with no marker.
  - Held at 0 while enable=0.
- Hit detect:
  - hit_q registers hit_i.
  - A rising edge on channel c is (hit_i[c] & ~hit_q[c] & enable), evaluated at clock edge k.
- Capture at edge k:
  - The channel slot loads {coarse value before increment, fine = encode(therm_i channel c)} and sets slot_valid[c].
  - If slot_valid[c] is already set and the slot is not being drained this cycle, the hit is discarded and drop_cnt increments (saturating at all-ones).
- Encoder (FINE_W result): index of the first 1→0 transition counting from tap 0, i.e. the count of leading ones.
  - All ones → TAPS.
  - tap 0 = 0 → 0.
- Arbiter:
  - Each cycle, at most one valid slot is moved to the FIFO, chosen round-robin starting at rr_ptr.
  - rr_ptr advances to the granted channel + 1, modulo NCH.
  - A grant requires the FIFO not full, or a pop in the same cycle.
  - A slot granted at edge k+1 may be reloaded by a new hit at edge k+1; this is not a drop.
- FIFO:
  - Show-ahead; rec_valid = ~empty.
  - A pop occurs when rec_valid & rec_ready.
  - Simultaneous push and pop keeps fifo_level unchanged, including at full.
  - rec_data is stable while rec_valid=1 and rec_ready=0.
- Latency: a hit edge sampled at edge k, with the FIFO empty and no contention, gives rec_valid=1 after edge k+1.
- enable deasserted: no new captures; pending slots and the FIFO continue to drain.
- Reset asserted mid-operation clears all pending records immediately. There is no flush handshake.

Optional Feature:
- Macro: TDC_BUBBLE_FIX_EN
- Defined: the encoder returns the population count of the thermometer code, giving bubble-tolerant fine values. Adds one pipeline register between the encoder and the slot load, so latency becomes rec_valid after edge k+2; drop and arbitration rules are unchanged and apply one cycle later.
- Undefined: leading-ones encoder with the latency above.

Decomposition:
- Package tdc_pkg holds:
  - the CH_W and FINE_W derivation functions;
  - record field offsets (FINE_LSB=0, COARSE_LSB=FINE_W, CH_LSB=FINE_W+COARSE_W);
  - the encoder mode constants.
- One sub-module, tdc_therm_enc:
  - parametrised by TAPS;
  - instantiated NCH times;
  - contains both encoder variants selected by TDC_BUBBLE_FIX_EN.
- The FIFO stays inline.

Test Plan:
- Single hit: NCH=2, TAPS=128, channel 0 therm with 37 leading ones, coarse=0x0100 at the edge, rec_ready=1 → one record {0, 0x0100, 37}, rec_valid one cycle, drop_cnt=0.
- Simultaneous hits on channels 0 and 1 at the same edge, rr_ptr=0 → channel 0 record, then channel 1 record on consecutive cycles; rr_ptr ends at 0.
- Same channel hit twice within one cycle of occupancy, with the FIFO full and rec_ready=0 → second hit dropped, drop_cnt=1. With 300 forced drops → drop_cnt=255.
- Backpressure: rec_ready=0, 16 hits spaced 4 cycles apart → fifo_level=16. Then push and pop in the same cycle → level stays 16 and the head data is correct.
- Encoder boundaries: all-ones → fine=128; all-zeros → 0. Bubble pattern 1110_1100 (LSB-first, 5 ones) → 3 without the macro, 5 with TDC_BUBBLE_FIX_EN.
- Coarse wrap at 0xFFFF→0x0000 with enable toggled, plus rst pulsed while the FIFO holds 5 records → after reset: level 0, rec_valid 0, coarse 0, drop_cnt 0.
